dm_arbiter: RTL and testbench
=============================

// Module: dm_arbiter
// PURPOSE
//  Shares the single data memory (DM) between two requesters: port 0 (CPU load/store) and port 1 (debug/DMA loader).
//  Sequences every access through latch -> access -> acknowledge and checks address alignment.
//  Drives the DM's Addr/WD/MemWrite/OpWidth/LoadSigned/WPC and returns registered read data per port.
//  Sits between the pipeline MEM stage and DM; DM writes on posedge, reads combinationally.
// PARAMETERS
//  FAIR       1      1: round-robin on simultaneous requests; 0: fixed priority, port 0 always wins
//  WORD       2'b00  OpWidth code, 32-bit access
//  HALF       2'b01  OpWidth code, 16-bit access
//  BYTE       2'b10  OpWidth code, 8-bit access
// PORTS
//  Clk          in   1   clock, all state on posedge
//  Reset        in   1   asynchronous, active-high reset
//  Req0/Req1    in   1   access request, held until AckN
//  We0/We1      in   1   1 = store, 0 = load
//  Addr0/Addr1  in   32  byte address
//  WD0/WD1      in   32  store data (low bits used for HALF/BYTE)
//  Width0/Width1 in  2   OpWidth code
//  Signed0/Signed1 in 1  sign-extend load
//  PC0/PC1      in   32  PC of the issuing instruction, forwarded to DM WPC
//  Ack0/Ack1    out  1   one-cycle done pulse
//  Err0/Err1    out  1   with AckN: access was misaligned/illegal and not performed
//  RD0/RD1      out  32  registered load data, valid from AckN until that port's next Ack
//  DMAddr       out  32  to DM Addr
//  DMWD         out  32  to DM WD
//  DMWrite      out  1   to DM MemWrite
//  DMWidth      out  2   to DM OpWidth
//  DMSigned     out  1   to DM LoadSigned
//  DMWPC        out  32  to DM WPC
//  DMRD         in   32  from DM RD (combinational)
// BEHAVIOUR
//  Reset (async, immediate): state=IDLE, Ack*/Err*=0, RD*=0, DMWrite=0, DM* buses=0, Last=1 (port 0 wins first tie).
//  FSM IDLE -> ACCESS -> DONE -> IDLE; one access per 3 cycles; never two accesses in flight.
//  IDLE: if neither Req, stay. Otherwise pick winner: one requester -> it; both -> FAIR ? port != Last : port 0.
//   Latch winner's We/Addr/WD/Width/Signed/PC and id into DM* regs and Sel; Last<=winner; -> ACCESS.
//  Alignment check on latched request: illegal if Width==2'b11, WORD with Addr[1:0]!=0, HALF with Addr[0]!=0.
//  ACCESS: DMWrite = latched We & legal (combinational from state, high only in ACCESS).
//   At the closing edge: RD[Sel] <= (legal & ~We) ? DMRD : 0; Ack[Sel]<=1; Err[Sel]<=~legal; -> DONE.
//   Store: RD[Sel] unchanged. Illegal: nothing written; RD[Sel] <= 0 for loads.
//  DONE: AckN/ErrN high exactly this cycle; requests ignored; -> IDLE; Ack/Err cleared on exit.
//  Latency: Req seen in IDLE at cycle T -> Ack high during cycle T+2; store committed at posedge ending T+1.
//  Requester holds all inputs stable until Ack; may drop Req or present a new request the cycle after Ack.
//  Changes to a port's inputs while it is not in service are ignored. The latched copy protects the in-flight access.
//  Req that is not granted stays pending; with FAIR=1 a waiting port is served before the other port's next access.
//  DM* buses hold the last latched values outside ACCESS; only DMWrite is forced 0.
//  Reset mid-ACCESS: DMWrite drops at once, store not committed, no Ack emitted.
//  RD of the non-selected port never changes.
// TESTING
//  Reset, Req0 store WORD Addr=0x10 WD=0xDEADBEEF -> DMWrite=1 only in cycle 2; Ack0 in cycle 3; DM[4]=DEADBEEF.
//  Req0 load HALF Addr=0x12 Signed=1 after above -> Ack0 2 cycles later; RD0=0xFFFFDEAD; RD1 unchanged.
//  Req0 and Req1 asserted together, held 4 accesses, FAIR=1 -> grants 0,1,0,1; FAIR=0 -> all grants go to port 0 while Req0 held.
//  Req1 load WORD Addr=0x6 -> Ack1=1, Err1=1, RD1=0, DMWrite never 1.
//  Req1 store BYTE Addr=0x13 WD=0xAB -> only DM[4][31:24] becomes 0xAB; DMWPC=PC1 during ACCESS.
//  Reset asserted mid-ACCESS of store -> DMWrite=0 immediately, memory unchanged, no Ack; FSM in IDLE.

Source files
------------

// File: rtl/dm_arbiter.sv
// Two-port arbiter for the single data memory: latches one request at a time,
// checks its alignment, drives the DM for one cycle and acknowledges with registered read data.
module dm_arbiter #(
  parameter bit         FAIR = 1'b1,
  parameter logic [1:0] WORD = 2'b00,
  parameter logic [1:0] HALF = 2'b01,
  parameter logic [1:0] BYTE = 2'b10
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Req0,
  input  logic        Req1,
  input  logic        We0,
  input  logic        We1,
  input  logic [31:0] Addr0,
  input  logic [31:0] Addr1,
  input  logic [31:0] WD0,
  input  logic [31:0] WD1,
  input  logic [1:0]  Width0,
  input  logic [1:0]  Width1,
  input  logic        Signed0,
  input  logic        Signed1,
  input  logic [31:0] PC0,
  input  logic [31:0] PC1,
  output logic        Ack0,
  output logic        Ack1,
  output logic        Err0,
  output logic        Err1,
  output logic [31:0] RD0,
  output logic [31:0] RD1,
  output logic [31:0] DMAddr,
  output logic [31:0] DMWD,
  output logic        DMWrite,
  output logic [1:0]  DMWidth,
  output logic        DMSigned,
  output logic [31:0] DMWPC,
  input  logic [31:0] DMRD,
  output logic [1:0]  DbgState
);

  // Handshake: a requester raises ReqN with all its inputs and holds them stable
  // until the one-cycle AckN pulse; the transfer completes on that Ack, and the
  // port may drop Req or present a new request in the following cycle.

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t state, state_nxt;
  logic   last;
  logic   sel;
  logic   lat_we;
  logic   legal;
  logic   grant_vld;
  logic   grant_id;

  // Winner selection: a lone requester wins; on a tie FAIR alternates away from Last.
  always_comb begin
    grant_vld = Req0 | Req1;
    grant_id  = 1'b0;
    if (Req1 && !Req0)
      grant_id = 1'b1;
    else if (Req1 && Req0 && FAIR)
      grant_id = ~last;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant_vld) state_nxt = ACCESS;
      ACCESS:  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state <= IDLE;
    else       state <= state_nxt;
  end

  assign DbgState = state;

  // Alignment is judged on the latched copy, so it is stable for the whole access.
  always_comb begin
    legal = 1'b0;
    case (DMWidth)
      WORD:    legal = (DMAddr[1:0] == 2'b00);
      HALF:    legal = ~DMAddr[0];
      BYTE:    legal = 1'b1;
      default: legal = 1'b0;
    endcase
  end

  assign DMWrite = (state == ACCESS) & lat_we & legal;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      last     <= 1'b1;
      sel      <= 1'b0;
      lat_we   <= 1'b0;
      DMAddr   <= '0;
      DMWD     <= '0;
      DMWidth  <= '0;
      DMSigned <= 1'b0;
      DMWPC    <= '0;
    end else if (state == IDLE && grant_vld) begin
      sel      <= grant_id;
      last     <= grant_id;
      lat_we   <= grant_id ? We1     : We0;
      DMAddr   <= grant_id ? Addr1   : Addr0;
      DMWD     <= grant_id ? WD1     : WD0;
      DMWidth  <= grant_id ? Width1  : Width0;
      DMSigned <= grant_id ? Signed1 : Signed0;
      DMWPC    <= grant_id ? PC1     : PC0;
    end
  end

  // Response registers: only the selected port's RD ever moves, and only for loads.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      Ack0 <= 1'b0;
      Ack1 <= 1'b0;
      Err0 <= 1'b0;
      Err1 <= 1'b0;
      RD0  <= '0;
      RD1  <= '0;
    end else begin
      case (state)
        ACCESS: begin
          if (sel) begin
            Ack1 <= 1'b1;
            Err1 <= ~legal;
            if (!lat_we) RD1 <= legal ? DMRD : '0;
          end else begin
            Ack0 <= 1'b1;
            Err0 <= ~legal;
            if (!lat_we) RD0 <= legal ? DMRD : '0;
          end
        end
        DONE: begin
          Ack0 <= 1'b0;
          Ack1 <= 1'b0;
          Err0 <= 1'b0;
          Err1 <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dm_arbiter.sv
// Bench for dm_arbiter: a byte-addressed little-endian DM model, a round-robin
// instance and a fixed-priority instance sharing stimulus, and a scoreboard queue.
module tb_dm_arbiter;

  localparam logic [1:0] W_WORD = 2'b00;
  localparam logic [1:0] W_HALF = 2'b01;
  localparam logic [1:0] W_BYTE = 2'b10;

  logic        Clk, Reset;
  logic        Req0, Req1, We0, We1, Signed0, Signed1;
  logic [31:0] Addr0, Addr1, WD0, WD1, PC0, PC1;
  logic [1:0]  Width0, Width1;
  logic        Ack0, Ack1, Err0, Err1, DMWrite, DMSigned;
  logic [31:0] RD0, RD1, DMAddr, DMWD, DMWPC, DMRD;
  logic [1:0]  DMWidth, DbgState;
  logic        f_Ack0, f_Ack1, f_Err0, f_Err1, f_DMWrite, f_DMSigned;
  logic [31:0] f_RD0, f_RD1, f_DMAddr, f_DMWD, f_DMWPC, f_DMRD;
  logic [1:0]  f_DMWidth, f_DbgState;

  logic [31:0] mem [0:63];
  logic        mem_load;
  logic [33:0] exp_q[$];
  logic [33:0] fix_q[$];
  int          n_checks, n_pass;

  dm_arbiter #(.FAIR(1'b1)) u_dut (
    .Clk(Clk), .Reset(Reset), .Req0(Req0), .Req1(Req1), .We0(We0), .We1(We1),
    .Addr0(Addr0), .Addr1(Addr1), .WD0(WD0), .WD1(WD1), .Width0(Width0), .Width1(Width1),
    .Signed0(Signed0), .Signed1(Signed1), .PC0(PC0), .PC1(PC1),
    .Ack0(Ack0), .Ack1(Ack1), .Err0(Err0), .Err1(Err1), .RD0(RD0), .RD1(RD1),
    .DMAddr(DMAddr), .DMWD(DMWD), .DMWrite(DMWrite), .DMWidth(DMWidth),
    .DMSigned(DMSigned), .DMWPC(DMWPC), .DMRD(DMRD), .DbgState(DbgState)
  );

  dm_arbiter #(.FAIR(1'b0)) u_fix (
    .Clk(Clk), .Reset(Reset), .Req0(Req0), .Req1(Req1), .We0(We0), .We1(We1),
    .Addr0(Addr0), .Addr1(Addr1), .WD0(WD0), .WD1(WD1), .Width0(Width0), .Width1(Width1),
    .Signed0(Signed0), .Signed1(Signed1), .PC0(PC0), .PC1(PC1),
    .Ack0(f_Ack0), .Ack1(f_Ack1), .Err0(f_Err0), .Err1(f_Err1), .RD0(f_RD0), .RD1(f_RD1),
    .DMAddr(f_DMAddr), .DMWD(f_DMWD), .DMWrite(f_DMWrite), .DMWidth(f_DMWidth),
    .DMSigned(f_DMSigned), .DMWPC(f_DMWPC), .DMRD(f_DMRD), .DbgState(f_DbgState)
  );

  // ---------------- clock / reset ----------------
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #300000;
    $display("FAIL global_timeout: simulation did not reach summary");
    $fatal(1);
  end

  // ---------------- DM model ----------------
  function automatic logic [31:0] dm_read(input logic [31:0] w, input logic [1:0] a,
                                          input logic [1:0] wd, input logic s);
    logic [31:0] sh;
    sh = w >> {a, 3'b000};
    case (wd)
      W_HALF:  return s ? {{16{sh[15]}}, sh[15:0]} : {16'h0, sh[15:0]};
      W_BYTE:  return s ? {{24{sh[7]}}, sh[7:0]} : {24'h0, sh[7:0]};
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] dm_merge(input logic [31:0] w, input logic [1:0] a,
                                           input logic [31:0] d, input logic [1:0] wd);
    logic [31:0] m;
    m = (wd == W_HALF) ? 32'h0000_FFFF : (wd == W_BYTE) ? 32'h0000_00FF : 32'hFFFF_FFFF;
    return (w & ~(m << {a, 3'b000})) | ((d & m) << {a, 3'b000});
  endfunction

  function automatic logic is_legal(input logic [31:0] a, input logic [1:0] wd);
    if (wd == 2'b11) return 1'b0;
    if (wd == W_WORD) return a[1:0] == 2'b00;
    if (wd == W_HALF) return ~a[0];
    return 1'b1;
  endfunction

  always @(posedge Clk) begin
    if (mem_load) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'h1000_0000 | i;
    end else if (DMWrite) begin
      mem[DMAddr[7:2]] <= dm_merge(mem[DMAddr[7:2]], DMAddr[1:0], DMWD, DMWidth);
    end
  end

  assign DMRD   = dm_read(mem[DMAddr[7:2]], DMAddr[1:0], DMWidth, DMSigned);
  assign f_DMRD = dm_read(mem[f_DMAddr[7:2]], f_DMAddr[1:0], f_DMWidth, f_DMSigned);

  // ---------------- driver tasks ----------------
  task automatic pulse_reset;
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    @(negedge Clk);
  endtask

  // Called at a negedge with the DUT idle; returns what was seen on the acknowledge.
  task automatic run_access(input logic port, input logic we, input logic [31:0] addr,
                            input logic [31:0] wd, input logic [1:0] width, input logic sgn,
                            input logic [31:0] pc, output logic [31:0] rd, output logic err,
                            output int lat, output int wr_n, output int wr_at,
                            output logic [31:0] wpc);
    rd = '0; err = 1'b0; lat = -1; wr_n = 0; wr_at = -1; wpc = '0;
    if (port) begin
      We1 = we; Addr1 = addr; WD1 = wd; Width1 = width; Signed1 = sgn; PC1 = pc; Req1 = 1'b1;
    end else begin
      We0 = we; Addr0 = addr; WD0 = wd; Width0 = width; Signed0 = sgn; PC0 = pc; Req0 = 1'b1;
    end
    for (int c = 1; c <= 8; c++) begin
      @(negedge Clk);
      if (DMWrite === 1'b1) begin wr_n++; wr_at = c; end
      if (DbgState == 2'd1) wpc = DMWPC;
      if ((port ? Ack1 : Ack0) === 1'b1) begin
        rd = port ? RD1 : RD0;
        err = port ? Err1 : Err0;
        lat = c;
        break;
      end
    end
    Req0 = 1'b0;
    Req1 = 1'b0;
    @(negedge Clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    Reset = 1'b1; mem_load = 1'b1;
    Req0 = 0; Req1 = 0; We0 = 0; We1 = 0; Signed0 = 0; Signed1 = 0;
    Addr0 = '0; Addr1 = '0; WD0 = '0; WD1 = '0; PC0 = '0; PC1 = '0; Width0 = '0; Width1 = '0;
    repeat (3) @(negedge Clk);
    n_checks++; if ({Ack0, Ack1, Err0, Err1} !== 4'b0) $display("FAIL reset_ack_err: got %b want 0000", {Ack0, Ack1, Err0, Err1}); else n_pass++;
    n_checks++; if ({RD0, RD1} !== 64'h0) $display("FAIL reset_rd: got %h %h want 0 0", RD0, RD1); else n_pass++;
    n_checks++; if (DMWrite !== 1'b0) $display("FAIL reset_dmwrite: got %b want 0", DMWrite); else n_pass++;
    n_checks++; if ({DMAddr, DMWD, DMWPC, DMWidth, DMSigned} !== 99'h0) $display("FAIL reset_dm_bus: got %h %h %h %b %b want all 0", DMAddr, DMWD, DMWPC, DMWidth, DMSigned); else n_pass++;
    n_checks++; if (DbgState !== 2'd0) $display("FAIL reset_state: got %0d want 0", DbgState); else n_pass++;
    mem_load = 1'b0;
    Reset = 1'b0;
    @(negedge Clk);
  endtask

  task automatic test_store_word;
    logic [31:0] rd, wpc; logic err; int lat, wr_n, wr_at; logic [33:0] e;
    exp_q.push_back({1'b0, 1'b0, 32'h0});
    run_access(1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF, W_WORD, 1'b0, 32'h100, rd, err, lat, wr_n, wr_at, wpc);
    e = exp_q.pop_front();
    n_checks++; if (lat !== 2) $display("FAIL store_latency: got %0d want 2", lat); else n_pass++;
    n_checks++; if (wr_n !== 1 || wr_at !== 1) $display("FAIL store_dmwrite_window: got n=%0d at=%0d want n=1 at=1", wr_n, wr_at); else n_pass++;
    n_checks++; if (rd !== e[31:0] || err !== e[32]) $display("FAIL store_resp: got rd=%h err=%b want rd=%h err=%b", rd, err, e[31:0], e[32]); else n_pass++;
    n_checks++; if (mem[4] !== 32'hDEAD_BEEF) $display("FAIL store_mem: got %h want deadbeef", mem[4]); else n_pass++;
    n_checks++; if (wpc !== 32'h100) $display("FAIL store_wpc: got %h want 00000100", wpc); else n_pass++;
    n_checks++; if (Ack0 !== 1'b0 || DMWrite !== 1'b0) $display("FAIL store_after: got ack=%b wr=%b want 0 0", Ack0, DMWrite); else n_pass++;
    n_checks++; if (DMAddr !== 32'h10) $display("FAIL store_addr_hold: got %h want 00000010", DMAddr); else n_pass++;
  endtask

  task automatic test_load_sizes;
    logic [31:0] rd, wpc; logic err; int lat, wr_n, wr_at; logic [33:0] e;
    logic [31:0] t_addr [3];
    logic [1:0]  t_w [3];
    logic        t_s [3];
    logic [31:0] t_exp [3];
    t_addr = '{32'h12, 32'h10, 32'h11};
    t_w    = '{W_HALF, W_HALF, W_BYTE};
    t_s    = '{1'b1, 1'b0, 1'b1};
    t_exp  = '{32'hFFFF_DEAD, 32'h0000_BEEF, 32'hFFFF_FFBE};
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back({1'b0, 1'b0, t_exp[i]});
      run_access(1'b0, 1'b0, t_addr[i], 32'h0, t_w[i], t_s[i], 32'h104, rd, err, lat, wr_n, wr_at, wpc);
      e = exp_q.pop_front();
      n_checks++; if (rd !== e[31:0] || err !== e[32]) $display("FAIL load_%0d_resp: got rd=%h err=%b want rd=%h err=%b", i, rd, err, e[31:0], e[32]); else n_pass++;
      n_checks++; if (lat !== 2 || wr_n !== 0) $display("FAIL load_%0d_timing: got lat=%0d writes=%0d want 2 0", i, lat, wr_n); else n_pass++;
      n_checks++; if (RD1 !== 32'h0) $display("FAIL load_%0d_rd1_untouched: got %h want 0", i, RD1); else n_pass++;
    end
  endtask

  task automatic test_fairness;
    logic [33:0] e;
    int acks;
    pulse_reset();
    We0 = 0; Addr0 = 32'h10; Width0 = W_WORD; Signed0 = 0;
    We1 = 0; Addr1 = 32'h14; Width1 = W_WORD; Signed1 = 0;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back((i % 2 == 0) ? {1'b0, 1'b0, 32'hDEAD_BEEF} : {1'b1, 1'b0, 32'h1000_0005});
      fix_q.push_back({1'b0, 1'b0, 32'hDEAD_BEEF});
    end
    Req0 = 1'b1; Req1 = 1'b1;
    acks = 0;
    for (int c = 0; c < 30 && acks < 4; c++) begin
      @(negedge Clk);
      if ((Ack0 | Ack1) === 1'b1 && exp_q.size() != 0) begin
        e = exp_q.pop_front();
        n_checks++; if (Ack1 !== e[33]) $display("FAIL fair_grant_%0d: got port %b want port %b", acks, Ack1, e[33]); else n_pass++;
        n_checks++; if ((Ack1 ? RD1 : RD0) !== e[31:0]) $display("FAIL fair_rd_%0d: got %h want %h", acks, Ack1 ? RD1 : RD0, e[31:0]); else n_pass++;
        acks++;
      end
      if ((f_Ack0 | f_Ack1) === 1'b1 && fix_q.size() != 0) begin
        e = fix_q.pop_front();
        n_checks++; if (f_Ack1 !== e[33]) $display("FAIL fixed_grant: got port %b want port %b", f_Ack1, e[33]); else n_pass++;
      end
    end
    Req0 = 1'b0; Req1 = 1'b0;
    n_checks++; if (exp_q.size() != 0 || fix_q.size() != 0) $display("FAIL fair_all_served: got %0d/%0d left want 0/0", exp_q.size(), fix_q.size()); else n_pass++;
    exp_q.delete(); fix_q.delete();
    repeat (2) @(negedge Clk);
  endtask

  task automatic test_misaligned;
    logic [31:0] rd, wpc; logic err; int lat, wr_n, wr_at; logic [33:0] e;
    logic        t_p [3];
    logic        t_we [3];
    logic [31:0] t_addr [3];
    logic [1:0]  t_w [3];
    logic [31:0] t_rd [3];
    t_p    = '{1'b1, 1'b1, 1'b0};
    t_we   = '{1'b1, 1'b0, 1'b0};
    t_addr = '{32'h11, 32'h6, 32'h0};
    t_w    = '{W_HALF, W_WORD, 2'b11};
    t_rd   = '{32'h1000_0005, 32'h0, 32'h0};
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back({t_p[i], 1'b1, t_rd[i]});
      run_access(t_p[i], t_we[i], t_addr[i], 32'hFFFF_FFFF, t_w[i], 1'b0, 32'h300, rd, err, lat, wr_n, wr_at, wpc);
      e = exp_q.pop_front();
      n_checks++; if (rd !== e[31:0] || err !== e[32]) $display("FAIL misalign_%0d_resp: got rd=%h err=%b want rd=%h err=%b", i, rd, err, e[31:0], e[32]); else n_pass++;
      n_checks++; if (wr_n !== 0 || lat !== 2) $display("FAIL misalign_%0d_nowrite: got writes=%0d lat=%0d want 0 2", i, wr_n, lat); else n_pass++;
    end
    n_checks++; if (mem[4] !== 32'hDEAD_BEEF) $display("FAIL misalign_mem: got %h want deadbeef", mem[4]); else n_pass++;
  endtask

  task automatic test_byte_store;
    logic [31:0] rd, wpc; logic err; int lat, wr_n, wr_at; logic [33:0] e;
    exp_q.push_back({1'b1, 1'b0, 32'h0});
    run_access(1'b1, 1'b1, 32'h13, 32'h0000_00AB, W_BYTE, 1'b0, 32'h200, rd, err, lat, wr_n, wr_at, wpc);
    e = exp_q.pop_front();
    n_checks++; if (rd !== e[31:0] || err !== e[32]) $display("FAIL byte_resp: got rd=%h err=%b want rd=%h err=%b", rd, err, e[31:0], e[32]); else n_pass++;
    n_checks++; if (wr_n !== 1 || wpc !== 32'h200) $display("FAIL byte_write_wpc: got writes=%0d wpc=%h want 1 00000200", wr_n, wpc); else n_pass++;
    n_checks++; if (mem[4] !== 32'hABAD_BEEF || mem[5] !== 32'h1000_0005) $display("FAIL byte_mem: got %h %h want abadbeef 10000005", mem[4], mem[5]); else n_pass++;
    exp_q.push_back({1'b1, 1'b0, 32'hABAD_BEEF});
    run_access(1'b1, 1'b0, 32'h10, 32'h0, W_WORD, 1'b0, 32'h204, rd, err, lat, wr_n, wr_at, wpc);
    e = exp_q.pop_front();
    n_checks++; if (rd !== e[31:0] || err !== e[32]) $display("FAIL byte_readback: got rd=%h err=%b want rd=%h err=%b", rd, err, e[31:0], e[32]); else n_pass++;
    n_checks++; if (RD0 !== 32'h0) $display("FAIL byte_rd0_untouched: got %h want 0", RD0); else n_pass++;
  endtask

  task automatic test_random;
    logic [31:0] rd, wpc, addr, data, exp_word; logic err, p, we, sgn, ok; logic [1:0] w;
    int lat, wr_n, wr_at; logic [33:0] e; logic [31:0] rd_model [2];
    pulse_reset();
    rd_model[0] = '0; rd_model[1] = '0;
    for (int i = 0; i < 10; i++) begin
      p    = 1'($urandom_range(0, 1));
      we   = 1'($urandom_range(0, 1));
      w    = 2'($urandom_range(0, 3));
      sgn  = 1'($urandom_range(0, 1));
      addr = 32'h40 + $urandom_range(0, 63);
      data = $urandom;
      ok   = is_legal(addr, w);
      exp_word = (we && ok) ? dm_merge(mem[addr[7:2]], addr[1:0], data, w) : mem[addr[7:2]];
      if (!we) rd_model[p] = ok ? dm_read(mem[addr[7:2]], addr[1:0], w, sgn) : 32'h0;
      exp_q.push_back({p, ~ok, rd_model[p]});
      run_access(p, we, addr, data, w, sgn, 32'h400 + i, rd, err, lat, wr_n, wr_at, wpc);
      e = exp_q.pop_front();
      n_checks++; if (rd !== e[31:0] || err !== e[32] || lat !== 2) $display("FAIL rand_%0d_resp: got rd=%h err=%b lat=%0d want rd=%h err=%b lat=2", i, rd, err, lat, e[31:0], e[32]); else n_pass++;
      n_checks++; if (mem[addr[7:2]] !== exp_word) $display("FAIL rand_%0d_mem: got %h want %h", i, mem[addr[7:2]], exp_word); else n_pass++;
      n_checks++; if ((p ? RD0 : RD1) !== rd_model[~p]) $display("FAIL rand_%0d_other_rd: got %h want %h", i, p ? RD0 : RD1, rd_model[~p]); else n_pass++;
    end
  endtask

  task automatic test_reset_mid_access;
    We0 = 1'b1; Addr0 = 32'h20; WD0 = 32'h1234_5678; Width0 = W_WORD; Signed0 = 1'b0; PC0 = 32'h500;
    Req0 = 1'b1;
    @(negedge Clk);
    n_checks++; if (DbgState !== 2'd1 || DMWrite !== 1'b1) $display("FAIL midrst_in_access: got state=%0d wr=%b want 1 1", DbgState, DMWrite); else n_pass++;
    Reset = 1'b1;
    #1;
    n_checks++; if (DMWrite !== 1'b0 || DbgState !== 2'd0) $display("FAIL midrst_immediate: got wr=%b state=%0d want 0 0", DMWrite, DbgState); else n_pass++;
    @(posedge Clk);
    #1;
    n_checks++; if (mem[8] !== 32'h1000_0008) $display("FAIL midrst_mem: got %h want 10000008", mem[8]); else n_pass++;
    @(negedge Clk);
    Req0 = 1'b0;
    Reset = 1'b0;
    @(negedge Clk);
    n_checks++; if (Ack0 !== 1'b0 || Err0 !== 1'b0 || DbgState !== 2'd0) $display("FAIL midrst_no_ack: got ack=%b err=%b state=%0d want 0 0 0", Ack0, Err0, DbgState); else n_pass++;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    n_checks = 0;
    n_pass   = 0;
    mem_load = 1'b1;
    test_reset();
    test_store_word();
    test_load_sizes();
    test_fairness();
    test_misaligned();
    test_byte_store();
    test_random();
    test_reset_mid_access();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
